w_matrix_ctrl: RTL and testbench
================================

Name: w_matrix_ctrl

Overview:
- Parametrised successor to the per-iteration weight-matrix decision stage of the one-unit FastICA datapath.
- Holds the N×N de-mixing matrix W in signed fixed point.
- Seeds W from an initial-value ROM on request or when the update engine reports an invalid result.
- Accepts updated matrices over a valid/ready handshake and checks each update element-by-element against the previous W.
- Reports convergence, or a timeout after MAX_ITER updates.
- Sits between the W-update engine and the unmixing multiplier array.

Parameters:
- N, 4, matrix dimension (channels); legal 2..8.
- DW, 26, element width, two's complement.
- FW, 13, fractional bits of the element format (Q(DW-FW).FW).
- EPS, 26'sd8, convergence threshold in LSBs; the matrix is converged when every |new-old| <= EPS.
- MAX_ITER, 64, update count after which timeout asserts.
- ITW, 7, iteration counter width; ITW >= clog2(MAX_ITER+1).

Ports:
- clk_b  in  1  clock, rising edge.
- rst_b  in  1  asynchronous active-high reset.
- en_b  in  1  clock enable; when low, all state, counters and outputs hold.
- init_req  in  1  single-cycle pulse: (re)load W from the ROM.
- upd_valid  in  1  update matrix present on iw_flat.
- upd_ready  out  1  block can accept an update.
- upd_invalid  in  1  qualifies the update: the engine's result is unusable, so reseed from the ROM.
- iw_flat  in  N*N*DW  update matrix, row-major; element (r,c) at bits [(r*N+c)*DW +: DW].
- ow_flat  out  N*N*DW  current committed W, same packing.
- w_valid  out  1  ow_flat holds a committed matrix.
- converged  out  1  sticky; the last committed update met EPS.
- timeout  out  1  sticky; MAX_ITER updates were committed without convergence.
- iter_cnt  out  ITW  number of committed updates since the last seed.

Behaviour:
- Reset (async): state=IDLE, ow_flat=0, shadow=0, w_valid=0, converged=0, timeout=0, iter_cnt=0, upd_ready=0. Reset mid-operation aborts any scan or load immediately.
- Everything below advances only on cycles with en_b=1.
- States:
  - IDLE: upd_ready=0. Goes to LOAD on init_req.
  - LOAD: writes one ROM element per cycle into ow_flat, index 0..N*N-1. w_valid=0 during LOAD. After the last element: w_valid=1, iter_cnt=0, converged=0, timeout=0, then RUN. LOAD lasts exactly N*N cycles.
  - RUN: upd_ready=1.
    - On upd_valid & upd_ready & upd_invalid: go to LOAD. The data is discarded and iter_cnt is not incremented.
    - On upd_valid & upd_ready & !upd_invalid: latch iw_flat into the shadow, clear the diff flag, go to CHECK.
  - CHECK: upd_ready=0. Scans one element per cycle.
    - d = shadow[i] - ow[i], computed in DW+1 bits; |d| also in DW+1 bits. The most-negative value is impossible at DW+1, so no overflow.
    - The diff flag sets if |d| > EPS.
    - After N*N cycles, go to COMMIT.
  - COMMIT (1 cycle):
    - ow_flat <= shadow.
    - iter_cnt increments, saturating at 2^ITW-1.
    - converged <= !diff flag.
    - timeout <= 1 if the new iter_cnt == MAX_ITER and the diff flag is set.
    - Next state: HALT if converged or timeout, else RUN.
  - HALT: upd_ready=0; ow_flat stable; only init_req leaves (to LOAD).
- init_req has priority in every state except LOAD, where it is ignored. In CHECK it discards the shadow and ow_flat is not modified.
- init_req and an accepted update in the same RUN cycle: init_req wins and the update is not consumed. upd_ready is combinationally deasserted when init_req=1.
- Update latency: handshake to new ow_flat = N*N+1 cycles; ow_flat changes on the COMMIT edge only.
- No arithmetic modifies W; elements pass through bit-exact. There is no row duplication or swapping; element (r,c) out equals element (r,c) in.

Decomposition:
- Shared package holds:
  - the element type (signed DW),
  - the state enum {IDLE, LOAD, RUN, CHECK, COMMIT, HALT},
  - the default ROM contents for N=4 (Q13.13): row1 -0.1493,-0.5911,0.37934,-0.1747; row2 2.449,-0.6547,-0.3303,-0.9573; row3 0.473,-1.0807,-0.4999,1.2925; row4 0.1169,-0.0477,-0.0359,0.4409.
- One sub-module, w_init_rom: combinational lookup of index -> DW-bit value. For N != 4 it returns the identity matrix scaled to 1.0.

Test Plan:
- Reset then init_req: after 16 cycles w_valid=1, ow element(1,0)=26'sd20062 (2.449), iter_cnt=0, upd_ready=1.
- Update with all elements = ROM+5 LSB: commits 17 cycles after handshake, converged=1, state HALT, iter_cnt=1, upd_ready=0.
- Update with element(3,3) = ROM+9 LSB, rest equal: converged=0, returns to RUN, and ow row 3 differs from row 2, proving no row duplication.
- upd_invalid=1 with upd_valid: reseeds; ow equals ROM after 16 cycles and iter_cnt stays 0.
- 64 updates each differing by 100 LSB: after the 64th COMMIT, timeout=1, converged=0, iter_cnt=64.
- Mid-operation cases:
  - Assert rst_b in the middle of CHECK: all outputs 0 on the same edge.
  - Separately, en_b=0 for 5 cycles during LOAD: load index and ow_flat are frozen, and completion is delayed exactly 5 cycles.

Source files
------------

// File: rtl/w_matrix_ctrl_pkg.sv
// Shared definitions for the de-mixing matrix controller: element type, FSM
// state encodings and the default Q13.13 seed matrix for the 4-channel build.
package w_matrix_ctrl_pkg;

  localparam int ROM_DW = 26;
  localparam int ROM_FW = 13;

  typedef logic signed [ROM_DW-1:0] w_elem_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  // Seed values rounded to nearest LSB of Q13.13, row-major.
  function automatic w_elem_t rom4_elem(input logic [3:0] idx);
    w_elem_t v;
    case (idx)
      4'd0:    v = -26'sd1223;
      4'd1:    v = -26'sd4842;
      4'd2:    v =  26'sd3108;
      4'd3:    v = -26'sd1431;
      4'd4:    v =  26'sd20062;
      4'd5:    v = -26'sd5363;
      4'd6:    v = -26'sd2706;
      4'd7:    v = -26'sd7842;
      4'd8:    v =  26'sd3875;
      4'd9:    v = -26'sd8853;
      4'd10:   v = -26'sd4095;
      4'd11:   v =  26'sd10588;
      4'd12:   v =  26'sd958;
      4'd13:   v = -26'sd391;
      4'd14:   v = -26'sd294;
      default: v =  26'sd3612;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/w_matrix_ctrl_rom.sv
// Initial-value lookup for W. The stored table is only meaningful for the
// 4x4 Q13.13 build; any other shape seeds the identity matrix at 1.0.
module w_init_rom
  import w_matrix_ctrl_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 26,
  parameter int FW = 13,
  parameter int AW = 4
) (
  input  logic [AW-1:0]        addr,
  output logic signed [DW-1:0] data
);

  localparam logic signed [DW-1:0] ONE = DW'(1) << FW;

  generate
    if (N == 4 && DW == ROM_DW && FW == ROM_FW) begin : g_table
      always_comb data = rom4_elem(addr[3:0]);
    end else begin : g_identity
      always_comb begin
        data = '0;
        if ((int'(addr) / N) == (int'(addr) % N)) data = ONE;
      end
    end
  endgenerate

endmodule

// File: rtl/w_matrix_ctrl.sv
// Holds the de-mixing matrix W, seeds it from ROM, and screens each proposed
// update element-by-element against the committed W before accepting it.
//   state  | meaning
//   IDLE   | no matrix yet, waiting for init_req
//   LOAD   | copying one ROM element per cycle into W
//   RUN    | ready for an update from the W-update engine
//   CHECK  | comparing shadow against W, one element per cycle
//   COMMIT | W <= shadow, update iteration and status flags
//   HALT   | converged or timed out, W frozen until init_req
module w_matrix_ctrl
  import w_matrix_ctrl_pkg::*;
#(
  parameter int                   N        = 4,
  parameter int                   DW       = 26,
  parameter int                   FW       = 13,
  parameter logic signed [DW-1:0] EPS      = 26'sd8,
  parameter int                   MAX_ITER = 64,
  parameter int                   ITW      = 7
) (
  input  logic                clk_b,
  input  logic                rst_b,
  input  logic                en_b,
  input  logic                init_req,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic                upd_invalid,
  input  logic [N*N*DW-1:0]   iw_flat,
  output logic [N*N*DW-1:0]   ow_flat,
  output logic                w_valid,
  output logic                converged,
  output logic                timeout,
  output logic [ITW-1:0]      iter_cnt
);

  localparam int             NE       = N * N;
  localparam int             IW       = $clog2(NE);
  localparam logic [IW-1:0]  IDX_LAST = IW'(NE - 1);
  localparam logic [ITW-1:0] ITER_SAT = '1;
  localparam logic [ITW-1:0] ITER_TO  = ITW'(MAX_ITER);

  logic [2:0]         state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NE*DW-1:0]   ow_q, ow_d;
  logic [NE*DW-1:0]   shadow_q, shadow_d;
  logic               w_valid_q, w_valid_d;
  logic               conv_q, conv_d;
  logic               tout_q, tout_d;
  logic               diff_q, diff_d;
  logic [ITW-1:0]     iter_q, iter_d;

  logic signed [DW-1:0] rom_data, cur_new, cur_old;
  logic signed [DW:0]   delta, delta_abs;
  logic                 exceeds, last_idx, accept;

  w_init_rom #(.N(N), .DW(DW), .FW(FW), .AW(IW)) u_rom (
    .addr (idx_q),
    .data (rom_data)
  );

  assign cur_new   = shadow_q[int'(idx_q)*DW +: DW];
  assign cur_old   = ow_q[int'(idx_q)*DW +: DW];
  assign delta     = {cur_new[DW-1], cur_new} - {cur_old[DW-1], cur_old};
  assign delta_abs = delta[DW] ? -delta : delta;
  assign exceeds   = delta_abs > $signed({EPS[DW-1], EPS});
  assign last_idx  = (idx_q == IDX_LAST);

  // Gated by en_b so the engine never sees a handshake the block would drop.
  assign upd_ready = (state_q == ST_RUN) && !init_req && en_b;
  assign accept    = upd_ready && upd_valid;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ow_d      = ow_q;
    shadow_d  = shadow_q;
    w_valid_d = w_valid_q;
    conv_d    = conv_q;
    tout_d    = tout_q;
    diff_d    = diff_q;
    iter_d    = iter_q;
    if (en_b) begin
      if (init_req && state_q != ST_LOAD) begin
        state_d   = ST_LOAD;
        idx_d     = '0;
        w_valid_d = 1'b0;
      end else begin
        case (state_q)
          ST_LOAD: begin
            ow_d[int'(idx_q)*DW +: DW] = rom_data;
            idx_d = idx_q + 1'b1;
            if (last_idx) begin
              idx_d     = '0;
              w_valid_d = 1'b1;
              iter_d    = '0;
              conv_d    = 1'b0;
              tout_d    = 1'b0;
              state_d   = ST_RUN;
            end
          end
          ST_RUN: begin
            if (accept && upd_invalid) begin
              state_d   = ST_LOAD;
              idx_d     = '0;
              w_valid_d = 1'b0;
            end else if (accept) begin
              shadow_d = iw_flat;
              diff_d   = 1'b0;
              idx_d    = '0;
              state_d  = ST_CHECK;
            end
          end
          ST_CHECK: begin
            diff_d = diff_q | exceeds;
            idx_d  = idx_q + 1'b1;
            if (last_idx) begin
              idx_d   = '0;
              state_d = ST_COMMIT;
            end
          end
          ST_COMMIT: begin
            ow_d    = shadow_q;
            iter_d  = (iter_q == ITER_SAT) ? iter_q : iter_q + 1'b1;
            conv_d  = !diff_q;
            tout_d  = (iter_d == ITER_TO) && diff_q;
            state_d = (!diff_q || tout_d) ? ST_HALT : ST_RUN;
          end
          ST_IDLE, ST_HALT: state_d = state_q;
          default:          state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_b or posedge rst_b) begin
    if (rst_b) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      ow_q      <= '0;
      shadow_q  <= '0;
      w_valid_q <= 1'b0;
      conv_q    <= 1'b0;
      tout_q    <= 1'b0;
      diff_q    <= 1'b0;
      iter_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ow_q      <= ow_d;
      shadow_q  <= shadow_d;
      w_valid_q <= w_valid_d;
      conv_q    <= conv_d;
      tout_q    <= tout_d;
      diff_q    <= diff_d;
      iter_q    <= iter_d;
    end
  end

  assign ow_flat   = ow_q;
  assign w_valid   = w_valid_q;
  assign converged = conv_q;
  assign timeout   = tout_q;
  assign iter_cnt  = iter_q;

endmodule

// File: tb/tb_w_matrix_ctrl.sv
// Directed-plus-random bench for w_matrix_ctrl with a max-|diff| matrix model.
module tb_w_matrix_ctrl;

  localparam int N = 4, DW = 26, FW = 13, NE = 16, MAX_ITER = 64, ITW = 7;
  localparam int EPSV = 8;
  localparam int VW = NE * DW;

  logic           clk_b = 1'b0;
  logic           rst_b = 1'b0;
  logic           en_b = 1'b1;
  logic           init_req = 1'b0;
  logic           upd_valid = 1'b0;
  logic           upd_invalid = 1'b0;
  logic [VW-1:0]  iw_flat = '0;
  logic           upd_ready, w_valid, converged, timeout;
  logic [VW-1:0]  ow_flat;
  logic [ITW-1:0] iter_cnt;

  int checks = 0;
  int failures = 0;

  real rom_real [NE] = '{-0.1493, -0.5911, 0.37934, -0.1747,
                         2.449, -0.6547, -0.3303, -0.9573,
                         0.473, -1.0807, -0.4999, 1.2925,
                         0.1169, -0.0477, -0.0359, 0.4409};
  int   rom_exp [NE];
  int   w_exp [NE];
  int   iter_exp;
  logic conv_exp, tout_exp;

  always #5 clk_b = ~clk_b;

  w_matrix_ctrl #(.N(N), .DW(DW), .FW(FW), .EPS(26'sd8), .MAX_ITER(MAX_ITER), .ITW(ITW)) dut (
    .clk_b(clk_b), .rst_b(rst_b), .en_b(en_b), .init_req(init_req),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_invalid(upd_invalid),
    .iw_flat(iw_flat), .ow_flat(ow_flat), .w_valid(w_valid),
    .converged(converged), .timeout(timeout), .iter_cnt(iter_cnt)
  );

  function automatic logic [VW-1:0] pack(input int m [NE]);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < NE; i++) v[i*DW +: DW] = DW'(m[i]);
    return v;
  endfunction

  function automatic int elem_of(input logic [VW-1:0] v, input int i);
    logic signed [DW-1:0] e;
    e = v[i*DW +: DW];
    return int'(e);
  endfunction

  function automatic int rand_full();
    logic signed [DW-1:0] r;
    r = DW'($urandom);
    return int'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_b);
    #1;
  endtask

  task automatic model_commit(input int nw [NE]);
    longint md, d;
    md = 0;
    for (int i = 0; i < NE; i++) begin
      d = longint'(nw[i]) - longint'(w_exp[i]);
      if (d < 0) d = -d;
      if (d > md) md = d;
    end
    w_exp = nw;
    if (iter_exp < 127) iter_exp++;
    conv_exp = (md <= EPSV);
    tout_exp = (iter_exp == MAX_ITER) && !conv_exp;
  endtask

  // Called one edge after the load was started (init edge or reseed handshake).
  task automatic finish_load();
    tick(NE - 1);
    chk("w_valid_during_load", w_valid, 0);
    tick(1);
    w_exp = rom_exp; iter_exp = 0; conv_exp = 0; tout_exp = 0;
    chk("w_valid_after_load", w_valid, 1);
    chk_w("ow_after_load", ow_flat, pack(w_exp));
    chk("iter_after_load", iter_cnt, 0);
    chk("conv_after_load", converged, 0);
    chk("tout_after_load", timeout, 0);
    chk("ready_after_load", upd_ready, 1);
  endtask

  task automatic do_load();
    init_req = 1'b1;
    tick(1);
    init_req = 1'b0;
    finish_load();
  endtask

  task automatic send_update(input int nw [NE]);
    iw_flat = pack(nw);
    upd_valid = 1'b1;
    upd_invalid = 1'b0;
    #1;
    chk("ready_before_handshake", upd_ready, 1);
    tick(1);
    upd_valid = 1'b0;
    for (int i = 0; i < NE; i++) iw_flat[i*DW +: DW] = DW'($urandom);
    tick(NE);
    chk_w("ow_held_until_commit", ow_flat, pack(w_exp));
    chk("ready_in_check", upd_ready, 0);
    tick(1);
    model_commit(nw);
    chk_w("ow_commit", ow_flat, pack(w_exp));
    chk("iter_commit", iter_cnt, iter_exp);
    chk("conv_commit", converged, conv_exp);
    chk("tout_commit", timeout, tout_exp);
    chk("ready_after_commit", upd_ready, !(conv_exp || tout_exp));
  endtask

  initial begin
    int nw [NE];
    int pick;
    logic [VW-1:0] snap, partial;

    for (int i = 0; i < NE; i++) begin
      real x;
      x = rom_real[i] * 8192.0;
      rom_exp[i] = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    end
    for (int i = 0; i < NE; i++) w_exp[i] = 0;
    iter_exp = 0; conv_exp = 0; tout_exp = 0;

    #2 rst_b = 1'b1;
    tick(2);
    rst_b = 1'b0;
    tick(1);
    chk_w("reset_ow", ow_flat, '0);
    chk("reset_w_valid", w_valid, 0);
    chk("reset_conv", converged, 0);
    chk("reset_tout", timeout, 0);
    chk("reset_iter", iter_cnt, 0);
    upd_valid = 1'b1;
    #1;
    chk("idle_ready", upd_ready, 0);
    upd_valid = 1'b0;

    do_load();
    chk("rom_elem_1_0", 32'(elem_of(ow_flat, 4)), 32'(20062));

    // All elements +5: converge and halt
    for (int i = 0; i < NE; i++) nw[i] = rom_exp[i] + 5;
    send_update(nw);
    chk("halt_conv", converged, 1);
    chk("halt_iter", iter_cnt, 1);
    upd_valid = 1'b1;
    tick(3);
    chk("halt_ready", upd_ready, 0);
    chk_w("halt_ow_stable", ow_flat, pack(w_exp));
    upd_valid = 1'b0;

    // Element (3,3) +9: not converged, back to RUN, rows stay distinct
    do_load();
    nw = rom_exp;
    nw[15] = rom_exp[15] + 9;
    send_update(nw);
    chk("e33_conv", converged, 0);
    chk("e33_ready", upd_ready, 1);
    checks++;
    assert (ow_flat[3*4*DW +: 4*DW] !== ow_flat[2*4*DW +: 4*DW]) else begin
      failures++;
      $error("FAIL row3_vs_row2 observed=%h expected_different_from=%h",
             ow_flat[3*4*DW +: 4*DW], ow_flat[2*4*DW +: 4*DW]);
    end

    // init_req during CHECK: shadow dropped, W untouched until reload
    for (int i = 0; i < NE; i++) nw[i] = rand_full();
    iw_flat = pack(nw);
    upd_valid = 1'b1;
    tick(1);
    upd_valid = 1'b0;
    tick(5);
    init_req = 1'b1;
    tick(1);
    init_req = 1'b0;
    chk_w("init_in_check_ow", ow_flat, pack(w_exp));
    chk("init_in_check_iter", iter_cnt, 1);
    chk("init_in_check_valid", w_valid, 0);
    finish_load();

    // Every element within +-EPS, at least one exactly at the boundary
    for (int i = 0; i < NE; i++) nw[i] = rom_exp[i] + int'($urandom_range(16)) - 8;
    pick = int'($urandom_range(NE - 1));
    nw[pick] = rom_exp[pick] + (($urandom_range(1) == 1) ? 8 : -8);
    send_update(nw);
    chk("eps_boundary_conv", converged, 1);

    // Random full-range values, then the extremes, then a repeat to converge
    do_load();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NE; i++) nw[i] = rand_full();
      send_update(nw);
    end
    for (int i = 0; i < NE; i++) nw[i] = 33554431;
    send_update(nw);
    for (int i = 0; i < NE; i++) nw[i] = -33554432;
    send_update(nw);
    send_update(nw);
    chk("extreme_conv", converged, 1);

    // Invalid update reseeds without counting
    do_load();
    for (int i = 0; i < NE; i++) nw[i] = rom_exp[i] + 100;
    send_update(nw);
    chk("pre_invalid_iter", iter_cnt, 1);
    for (int i = 0; i < NE; i++) iw_flat[i*DW +: DW] = DW'($urandom);
    upd_valid = 1'b1;
    upd_invalid = 1'b1;
    #1;
    chk("invalid_ready", upd_ready, 1);
    tick(1);
    upd_valid = 1'b0;
    upd_invalid = 1'b0;
    finish_load();

    // init_req wins over a simultaneous update
    for (int i = 0; i < NE; i++) iw_flat[i*DW +: DW] = DW'($urandom);
    upd_valid = 1'b1;
    init_req = 1'b1;
    #1;
    chk("ready_masked_by_init", upd_ready, 0);
    tick(1);
    upd_valid = 1'b0;
    init_req = 1'b0;
    finish_load();

    // MAX_ITER non-converging updates
    for (int k = 0; k < MAX_ITER; k++) begin
      for (int i = 0; i < NE; i++) nw[i] = w_exp[i] + (($urandom_range(1) == 1) ? 100 : -100);
      send_update(nw);
    end
    chk("timeout_final", timeout, 1);
    chk("timeout_conv", converged, 0);
    chk("timeout_iter", iter_cnt, MAX_ITER);
    chk("timeout_ready", upd_ready, 0);

    // Asynchronous reset in the middle of CHECK
    do_load();
    for (int i = 0; i < NE; i++) nw[i] = rand_full();
    iw_flat = pack(nw);
    upd_valid = 1'b1;
    tick(1);
    upd_valid = 1'b0;
    tick(5);
    rst_b = 1'b1;
    #1;
    chk_w("midrst_ow", ow_flat, '0);
    chk("midrst_valid", w_valid, 0);
    chk("midrst_iter", iter_cnt, 0);
    chk("midrst_ready", upd_ready, 0);
    chk("midrst_conv", converged, 0);
    tick(1);
    rst_b = 1'b0;

    // Clock enable low for 5 cycles during LOAD
    init_req = 1'b1;
    tick(1);
    init_req = 1'b0;
    tick(5);
    partial = '0;
    for (int i = 0; i < 5; i++) partial[i*DW +: DW] = DW'(rom_exp[i]);
    chk_w("en_partial_load", ow_flat, partial);
    en_b = 1'b0;
    tick(5);
    chk_w("en_frozen_ow", ow_flat, partial);
    en_b = 1'b1;
    tick(NE - 6);
    chk("en_delay_valid_low", w_valid, 0);
    snap = ow_flat;
    partial[15*DW +: DW] = snap[15*DW +: DW];
    for (int i = 5; i < NE - 1; i++) partial[i*DW +: DW] = DW'(rom_exp[i]);
    chk_w("en_late_partial", snap, partial);
    tick(1);
    chk("en_delay_valid_high", w_valid, 1);
    chk_w("en_final_ow", ow_flat, pack(rom_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
